// File: rtl/conn_aging_manager.sv
// conn_aging_manager: per-connection idle tracking and expiry.
// Hits stamp an entry with the current coarse timestamp, closes clear it.
// A periodic scan walks the table and pushes one delete per expired entry
// toward connection_manager, holding on its ready.
module conn_aging_manager #(
  parameter int w_flowID      = 16,
  parameter int d_agingTb     = 3,
  parameter int w_ts          = 16,
  parameter int TICK_DIV      = 1024,
  parameter int SCAN_INTERVAL = 65536,
  parameter int TIMEOUT_INIT  = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hit_valid,
  input  logic [w_flowID-1:0] hit_flowID,
  input  logic                close_valid,
  input  logic [w_flowID-1:0] close_flowID,
  input  logic                ready,
  output logic                del_conn_valid,
  output logic [w_flowID-1:0] del_conn_info,
  output logic                scan_busy,
  input  logic                ctrl_in_valid,
  input  logic [1:0]          ctrl_opt,
  input  logic [31:0]         ctrl_addr,
  input  logic [31:0]         ctrl_data_in,
  output logic                ctrl_out_valid,
  output logic [31:0]         ctrl_data_out
);

  localparam int DEPTH = 1 << d_agingTb;
  localparam logic [w_ts-1:0]      TIMEOUT_RST = w_ts'(TIMEOUT_INIT);
  localparam logic [31:0]          TICK_LAST   = 32'(TICK_DIV - 1);
  localparam logic [31:0]          SCAN_LAST   = 32'(SCAN_INTERVAL - 1);
  localparam logic [d_agingTb-1:0] IDX_LAST    = {d_agingTb{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WAIT  = 2'd2
  } state_t;

  logic [DEPTH-1:0]     ent_valid;
  logic [w_ts-1:0]      ent_ts [DEPTH];
  logic [w_ts-1:0]      now;
  logic [w_ts-1:0]      timeout;
  logic [31:0]          prescaler;
  logic [31:0]          scan_timer;
  logic [31:0]          expired_cnt;
  logic [31:0]          rd_data;
  state_t               state, state_next, adv_state;
  logic [d_agingTb-1:0] idx, idx_next, adv_idx;
  logic [d_agingTb-1:0] hit_idx, close_idx;
  logic [w_ts-1:0]      age;
  logic                 stale, hit_here, close_here, do_del, scan_start;
  logic                 unused_bits;

  assign hit_idx     = hit_flowID[d_agingTb-1:0];
  assign close_idx   = close_flowID[d_agingTb-1:0];
  assign unused_bits = ^{hit_flowID, close_flowID, ctrl_data_in};

  // Age is taken modulo 2^w_ts so a timestamp wrap still ages correctly.
  assign age        = now - ent_ts[idx];
  assign stale      = ent_valid[idx] && (timeout != '0) && (age >= timeout);
  assign hit_here   = hit_valid && (hit_idx == idx);
  assign close_here = close_valid && (close_idx == idx);
  assign scan_start = (scan_timer == SCAN_LAST);

  assign del_conn_valid = do_del;
  assign del_conn_info  = do_del ? w_flowID'(idx) : '0;
  assign scan_busy      = (state != IDLE);

  // Free-running prescaler, coarse timestamp and scan interval timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= 32'd0;
      now        <= '0;
      scan_timer <= 32'd0;
    end else begin
      if (prescaler == TICK_LAST) begin
        prescaler <= 32'd0;
        now       <= now + 1'b1;
      end else begin
        prescaler <= prescaler + 32'd1;
      end
      if (scan_timer == SCAN_LAST) begin
        scan_timer <= 32'd0;
      end else begin
        scan_timer <= scan_timer + 32'd1;
      end
    end
  end

  // Scan FSM next state; a hit or close on the scanned entry beats the delete.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    do_del     = 1'b0;
    adv_state  = (idx == IDX_LAST) ? IDLE : CHECK;
    adv_idx    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    case (state)
      IDLE: begin
        if (scan_start) begin
          state_next = CHECK;
          idx_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      CHECK: begin
        if (stale && !hit_here) begin
          state_next = WAIT;
        end else begin
          state_next = adv_state;
          idx_next   = adv_idx;
        end
      end
      WAIT: begin
        if (hit_here || close_here || !stale) begin
          state_next = adv_state;
          idx_next   = adv_idx;
        end else if (ready) begin
          do_del     = 1'b1;
          state_next = adv_state;
          idx_next   = adv_idx;
        end else begin
          state_next = WAIT;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Scan FSM state and index registers; reset aborts any scan in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Aging table: hit stamps, close clears (close applied last so it wins).
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_ts[i] <= '0;
      end
    end else begin
      if (hit_valid) begin
        ent_valid[hit_idx] <= 1'b1;
        ent_ts[hit_idx]    <= now;
      end
      if (close_valid) begin
        ent_valid[close_idx] <= 1'b0;
      end
      if (do_del) begin
        ent_valid[idx] <= 1'b0;
      end
    end
  end

  // Control register read mux.
  always_comb begin
    rd_data = 32'd0;
    case (ctrl_addr)
      32'd0:   rd_data = 32'(timeout);
      32'd1:   rd_data = expired_cnt;
      default: rd_data = 32'd0;
    endcase
  end

  // Control registers, registered read port and saturating expiry counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout        <= TIMEOUT_RST;
      expired_cnt    <= 32'd0;
      ctrl_out_valid <= 1'b0;
      ctrl_data_out  <= 32'd0;
    end else begin
      ctrl_out_valid <= ctrl_in_valid && (ctrl_opt == 2'd1);
      if (ctrl_in_valid && (ctrl_opt == 2'd1)) begin
        ctrl_data_out <= rd_data;
      end
      if (ctrl_in_valid && (ctrl_opt == 2'd2) && (ctrl_addr == 32'd0)) begin
        timeout <= ctrl_data_in[w_ts-1:0];
      end
      if (do_del && (expired_cnt != 32'hFFFF_FFFF)) begin
        expired_cnt <= expired_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_conn_aging_manager.sv
// Directed bench for conn_aging_manager (fast tick/scan, 8-bit timestamps).
module tb_conn_aging_manager;

  logic        clk = 1'b0;
  logic        reset;
  logic        hit_valid, close_valid, ready;
  logic [15:0] hit_flowID, close_flowID;
  logic        del_conn_valid, scan_busy;
  logic [15:0] del_conn_info;
  logic        ctrl_in_valid, ctrl_out_valid;
  logic [1:0]  ctrl_opt;
  logic [31:0] ctrl_addr, ctrl_data_in, ctrl_data_out;

  int total = 0;
  int bad   = 0;
  int del_count = 0;

  conn_aging_manager #(
    .w_flowID(16), .d_agingTb(3), .w_ts(8),
    .TICK_DIV(4), .SCAN_INTERVAL(16), .TIMEOUT_INIT(100)
  ) dut (
    .clk(clk), .reset(reset),
    .hit_valid(hit_valid), .hit_flowID(hit_flowID),
    .close_valid(close_valid), .close_flowID(close_flowID),
    .ready(ready),
    .del_conn_valid(del_conn_valid), .del_conn_info(del_conn_info),
    .scan_busy(scan_busy),
    .ctrl_in_valid(ctrl_in_valid), .ctrl_opt(ctrl_opt),
    .ctrl_addr(ctrl_addr), .ctrl_data_in(ctrl_data_in),
    .ctrl_out_valid(ctrl_out_valid), .ctrl_data_out(ctrl_data_out)
  );

  always #5 clk = ~clk;

  // Count every cycle the delete strobe is high.
  always @(negedge clk) begin
    if (del_conn_valid === 1'b1) del_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; hit_valid = 1'b0; close_valid = 1'b0; ready = 1'b1;
    hit_flowID = 16'd0; close_flowID = 16'd0;
    ctrl_in_valid = 1'b0; ctrl_opt = 2'd0; ctrl_addr = 32'd0; ctrl_data_in = 32'd0;
    tick(3);
    reset = 1'b0;
  endtask

  // Drives one write strobe; returns at posedge+1 after it was sampled.
  task automatic ctrl_write(input logic [31:0] addr, input logic [31:0] data);
    ctrl_in_valid = 1'b1; ctrl_opt = 2'd2; ctrl_addr = addr; ctrl_data_in = data;
    tick(1);
    ctrl_in_valid = 1'b0; ctrl_opt = 2'd0;
  endtask

  // Read strobe; samples response one cycle later, returns at posedge+1.
  task automatic ctrl_read(input logic [31:0] addr, output logic vld, output logic [31:0] data);
    ctrl_in_valid = 1'b1; ctrl_opt = 2'd1; ctrl_addr = addr;
    tick(1);
    ctrl_in_valid = 1'b0; ctrl_opt = 2'd0;
    @(negedge clk);
    vld = ctrl_out_valid; data = ctrl_data_out;
    tick(1);
  endtask

  task automatic wait_del(input int max_cycles, output bit found, output logic [15:0] info);
    found = 1'b0; info = 16'd0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      @(negedge clk);
      if (del_conn_valid === 1'b1) begin
        found = 1'b1; info = del_conn_info;
      end
    end
    tick(1);
  endtask

  initial begin
    logic        vld;
    logic [31:0] rd;
    bit          found;
    logic [15:0] info;
    int          c0;

    // Reset state and timeout reset value.
    do_reset();
    @(negedge clk);
    chk("rst_del_valid", 32'(del_conn_valid), 32'd0);
    chk("rst_scan_busy", 32'(scan_busy), 32'd0);
    chk("rst_ctrl_valid", 32'(ctrl_out_valid), 32'd0);
    chk("rst_ctrl_data", ctrl_data_out, 32'd0);
    tick(1);
    ctrl_read(32'd0, vld, rd);
    chk("rd0_valid", 32'(vld), 32'd1);
    chk("rd0_timeout", rd, 32'd100);
    @(negedge clk);
    chk("rd0_valid_drop", 32'(ctrl_out_valid), 32'd0);
    chk("rd0_data_hold", ctrl_data_out, 32'd100);

    // Basic expiry of flowID 5 with timeout 3.
    do_reset();
    hit_valid = 1'b1; hit_flowID = 16'd5;
    ctrl_write(32'd0, 32'd3);
    hit_valid = 1'b0;
    wait_del(60, found, info);
    chk("basic_found", 32'(found), 32'd1);
    chk("basic_info", 32'(info), 32'd5);
    c0 = del_count;
    tick(60);
    chk("basic_once", 32'(del_count - c0), 32'd0);
    ctrl_read(32'd1, vld, rd);
    chk("basic_cnt", rd, 32'd1);
    ctrl_write(32'd1, 32'd55);
    @(negedge clk);
    chk("wr_no_valid", 32'(ctrl_out_valid), 32'd0);
    tick(1);
    ctrl_read(32'd1, vld, rd);
    chk("cnt_ro", rd, 32'd1);
    ctrl_read(32'd7, vld, rd);
    chk("rd_unknown_valid", 32'(vld), 32'd1);
    chk("rd_unknown", rd, 32'd0);
    ctrl_read(32'd0, vld, rd);
    chk("rd_timeout3", rd, 32'd3);

    // Refresh: hits every 8 cycles keep flowID 5 alive.
    c0 = del_count;
    for (int i = 0; i < 25; i++) begin
      hit_valid = 1'b1; hit_flowID = 16'd5;
      tick(1);
      hit_valid = 1'b0;
      tick(7);
    end
    chk("refresh_no_del", 32'(del_count - c0), 32'd0);

    // Backpressure on expired flowID 2.
    do_reset();
    ready = 1'b0;
    hit_valid = 1'b1; hit_flowID = 16'd2;
    ctrl_write(32'd0, 32'd3);
    hit_valid = 1'b0;
    tick(30);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_del", 32'(del_conn_valid), 32'd0);
      chk("bp_hold_busy", 32'(scan_busy), 32'd1);
    end
    tick(1);
    ready = 1'b1;
    @(negedge clk);
    chk("bp_pulse", 32'(del_conn_valid), 32'd1);
    chk("bp_info", 32'(del_conn_info), 32'd2);
    @(negedge clk);
    chk("bp_single", 32'(del_conn_valid), 32'd0);
    tick(1);
    c0 = del_count;
    tick(40);
    chk("bp_no_more", 32'(del_count - c0), 32'd0);

    // Race: hit on idx 3 while parked in WAIT.
    do_reset();
    ready = 1'b0;
    hit_valid = 1'b1; hit_flowID = 16'd3;
    ctrl_write(32'd0, 32'd3);
    hit_valid = 1'b0;
    tick(30);
    @(negedge clk);
    chk("race_hit_busy", 32'(scan_busy), 32'd1);
    tick(1);
    ready = 1'b1; hit_valid = 1'b1; hit_flowID = 16'd3;
    @(negedge clk);
    chk("race_hit_no_del", 32'(del_conn_valid), 32'd0);
    tick(1);
    hit_valid = 1'b0;
    c0 = del_count;
    tick(4);
    chk("race_hit_after", 32'(del_count - c0), 32'd0);

    // Race: close on idx 3 while parked in WAIT; never deleted later.
    do_reset();
    ready = 1'b0;
    hit_valid = 1'b1; hit_flowID = 16'd3;
    ctrl_write(32'd0, 32'd3);
    hit_valid = 1'b0;
    tick(30);
    ready = 1'b1; close_valid = 1'b1; close_flowID = 16'd3;
    @(negedge clk);
    chk("race_close_no_del", 32'(del_conn_valid), 32'd0);
    tick(1);
    close_valid = 1'b0;
    c0 = del_count;
    tick(100);
    chk("race_close_never", 32'(del_count - c0), 32'd0);
    ctrl_read(32'd1, vld, rd);
    chk("race_close_cnt", rd, 32'd0);

    // Hit and close on the same index in one cycle: close wins.
    do_reset();
    hit_valid = 1'b1; hit_flowID = 16'd4;
    close_valid = 1'b1; close_flowID = 16'd4;
    ctrl_write(32'd0, 32'd3);
    hit_valid = 1'b0; close_valid = 1'b0;
    c0 = del_count;
    tick(60);
    chk("close_wins", 32'(del_count - c0), 32'd0);

    // Timeout 0 disables aging across several scans.
    do_reset();
    hit_valid = 1'b1; hit_flowID = 16'd0;
    ctrl_write(32'd0, 32'd0);
    hit_flowID = 16'd1; tick(1);
    hit_flowID = 16'd7; tick(1);
    hit_valid = 1'b0;
    c0 = del_count;
    tick(64);
    chk("disable_no_del", 32'(del_count - c0), 32'd0);

    // Timestamp wrap: stamp at now=254, expire once at now=1 after 255->0.
    do_reset();
    ctrl_write(32'd0, 32'd0);
    tick(1016);
    c0 = del_count;
    hit_valid = 1'b1; hit_flowID = 16'd6;
    ctrl_write(32'd0, 32'd3);
    hit_valid = 1'b0;
    wait_del(80, found, info);
    chk("wrap_found", 32'(found), 32'd1);
    chk("wrap_info", 32'(info), 32'd6);
    tick(60);
    chk("wrap_once", 32'(del_count - c0), 32'd1);
    ctrl_read(32'd1, vld, rd);
    chk("wrap_cnt", rd, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
